// File: rtl/fpga_cfg_pkg.sv
// Shared types and helpers for the fpgav2 serial configuration loader.
// Holds the default chain geometry, the loader state encoding and word-count math.
package fpga_cfg_pkg;

  localparam int unsigned CHAIN_LEN_DEFAULT = 1480;
  localparam int unsigned WORD_W_DEFAULT    = 32;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StSetup,
    StHigh,
    StLow,
    StFinish
  } cfg_state_e;

  function automatic int unsigned words_per_load(input int unsigned len, input int unsigned w);
    return (len + w - 1) / w;
  endfunction

endpackage

// File: rtl/cfg_phase_timer.sv
// Down-counter that times one prog_clk phase of Div clk cycles.
// Reloads whenever disabled so every timed phase starts from a full count.
module cfg_phase_timer #(
  parameter int unsigned Div = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic phase_done_o
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign phase_done_o = en_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || (cnt_q == '0)) begin
      cnt_d = CntMax;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= CntMax;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fpga_config_loader.sv
// Streams bitstream words LSB-first into the fpgav2 program chain while
// capturing the previous chain contents from prog_out as readback words.
module fpga_config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter int unsigned WORD_W    = WORD_W_DEFAULT,
  parameter int unsigned CLK_DIV   = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic                           abort_i,
  input  logic [WORD_W-1:0]              cfg_data_i,
  input  logic                           cfg_valid_i,
  output logic                           cfg_ready_o,
  output logic                           prog_in_o,
  output logic                           prog_clk_o,
  output logic                           prog_en_o,
  input  logic                           prog_out_i,
  output logic [WORD_W-1:0]              rb_data_o,
  output logic                           rb_valid_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           aborted_o,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count_o
);

  localparam int unsigned BcW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WbW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BcW-1:0] LastBit     = BcW'(CHAIN_LEN - 1);
  localparam logic [WbW-1:0] LastWordBit = WbW'(WORD_W - 1);

  cfg_state_e        state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] rb_shift_q, rb_shift_d;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic [WbW-1:0]    word_bit_q, word_bit_d;
  logic [BcW-1:0]    bit_count_q, bit_count_d;
  logic              rb_valid_q, rb_valid_d;
  logic              aborted_q, aborted_d;

  logic timed;
  logic phase_done;
  logic last_bit;
  logic word_end;

  assign timed    = (state_q == StSetup) || (state_q == StHigh) || (state_q == StLow);
  assign last_bit = (bit_count_q == LastBit);
  assign word_end = (word_bit_q == LastWordBit);

  cfg_phase_timer #(
    .Div (CLK_DIV)
  ) u_phase_timer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (timed),
    .phase_done_o (phase_done)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    rb_shift_d  = rb_shift_q;
    rb_data_d   = rb_data_q;
    word_bit_d  = word_bit_q;
    bit_count_d = bit_count_q;
    rb_valid_d  = 1'b0;
    aborted_d   = aborted_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StFetch;
          aborted_d   = 1'b0;
          bit_count_d = '0;
          word_bit_d  = '0;
        end
      end
      StFetch: begin
        if (cfg_valid_i) begin
          shift_d    = cfg_data_i;
          word_bit_d = '0;
          state_d    = StSetup;
        end
      end
      StSetup: begin
        if (phase_done) begin
          // Chain-end bit before this shift; clearing on bit 0 zero-pads a short final word.
          if (word_bit_q == '0) begin
            rb_shift_d = '0;
          end
          rb_shift_d[word_bit_q] = prog_out_i;
          if (word_end || last_bit) begin
            rb_valid_d = 1'b1;
            rb_data_d  = rb_shift_d;
          end
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (phase_done) begin
          state_d = StLow;
        end
      end
      StLow: begin
        if (phase_done) begin
          bit_count_d = bit_count_q + 1'b1;
          shift_d     = shift_q >> 1;
          word_bit_d  = word_bit_q + 1'b1;
          if (last_bit) begin
            state_d = StFinish;
          end else if (word_end) begin
            state_d = StFetch;
          end else begin
            state_d = StSetup;
          end
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort beats a same-cycle handshake, readback completion or finish.
    if (abort_i && (state_q != StIdle)) begin
      state_d    = StIdle;
      aborted_d  = 1'b1;
      rb_valid_d = 1'b0;
      rb_data_d  = rb_data_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      rb_shift_q  <= '0;
      rb_data_q   <= '0;
      word_bit_q  <= '0;
      bit_count_q <= '0;
      rb_valid_q  <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      rb_shift_q  <= rb_shift_d;
      rb_data_q   <= rb_data_d;
      word_bit_q  <= word_bit_d;
      bit_count_q <= bit_count_d;
      rb_valid_q  <= rb_valid_d;
      aborted_q   <= aborted_d;
    end
  end

  assign cfg_ready_o = (state_q == StFetch) && !abort_i;
  assign prog_en_o   = timed || (state_q == StFetch);
  assign prog_clk_o  = (state_q == StHigh);
  assign prog_in_o   = timed && shift_q[0];
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StFinish);
  assign rb_data_o   = rb_data_q;
  assign rb_valid_o  = rb_valid_q;
  assign aborted_o   = aborted_q;
  assign bit_count_o = bit_count_q;

endmodule
